// File: rtl/lsu_remote_resp_pkg.sv
// rtl/lsu_remote_resp_pkg.sv - shared types for the remote response receive path
package lsu_remote_resp_pkg;

    localparam int RESP_DATA_W = 32;
    localparam int RESP_REG_W  = 5;

    typedef struct packed {
        logic       float_wb;
        logic       icache_fetch;
        logic       is_unsigned_op;
        logic       is_byte_op;
        logic       is_hex_op;
        logic [1:0] part_sel;
    } load_info_s;

    typedef struct packed {
        load_info_s             load_info;
        logic [RESP_REG_W-1:0]  reg_id;
        logic [RESP_DATA_W-1:0] data;
    } lsu_resp_s;

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - selects the addressed byte/halfword of a load response and extends it
module lsu_load_align
    import lsu_remote_resp_pkg::*;
(
    input  logic [RESP_DATA_W-1:0] data_i,
    input  load_info_s             info_i,
    output logic [RESP_DATA_W-1:0] data_o
);

    logic [7:0]  byte_w;
    logic [15:0] half_w;
    logic        sign_ext;

    always_comb begin
        byte_w   = data_i[7:0];
        half_w   = info_i.part_sel[1] ? data_i[31:16] : data_i[15:0];
        sign_ext = 1'b0;
        data_o   = data_i;
        case (info_i.part_sel)
            2'd1:    byte_w = data_i[15:8];
            2'd2:    byte_w = data_i[23:16];
            2'd3:    byte_w = data_i[31:24];
            default: byte_w = data_i[7:0];
        endcase
        if (info_i.is_byte_op) begin
            sign_ext = ~info_i.is_unsigned_op & byte_w[7];
            data_o   = {{24{sign_ext}}, byte_w};
        end else if (info_i.is_hex_op) begin
            sign_ext = ~info_i.is_unsigned_op & half_w[15];
            data_o   = {{16{sign_ext}}, half_w};
        end
    end

endmodule

// File: rtl/lsu_remote_resp_fifo.sv
// rtl/lsu_remote_resp_fifo.sv - two-entry registered response queue with registered ready
module lsu_remote_resp_fifo #(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               enq_v_i,
    input  logic [width_p-1:0] enq_data_i,
    output logic               ready_o,
    input  logic               deq_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o
);

    logic [width_p-1:0] mem_q [2];
    logic [width_p-1:0] mem_d [2];
    logic wptr_q, wptr_d, rptr_q, rptr_d;
    logic full_q, full_d, empty_q, empty_d;
    logic enq, deq;

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        full_d  = full_q;
        empty_d = empty_q;
        // A full queue refuses new data even when the head leaves this cycle.
        enq = enq_v_i & ~full_q;
        deq = deq_i & ~empty_q;
        if (enq) begin
            mem_d[wptr_q] = enq_data_i;
            wptr_d        = ~wptr_q;
        end
        if (deq) begin
            rptr_d = ~rptr_q;
        end
        if (enq && !deq) begin
            empty_d = 1'b0;
            full_d  = (wptr_d == rptr_q);
        end else if (deq && !enq) begin
            full_d  = 1'b0;
            empty_d = (rptr_d == wptr_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign ready_o = ~full_q;
    assign v_o     = ~empty_q;
    assign data_o  = mem_q[rptr_q];

endmodule

// File: rtl/lsu_remote_resp.sv
// rtl/lsu_remote_resp.sv - buffers remote load/AMO/fetch responses and routes them to int RF, FP RF or icache
module lsu_remote_resp
    import lsu_remote_resp_pkg::*;
#(
    parameter int data_width_p     = 32,
    parameter int reg_addr_width_p = 5,
    parameter int max_out_p        = 16
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        issue_v_i,
    output logic                        credit_avail_o,
    input  logic                        resp_v_i,
    output logic                        resp_ready_o,
    input  logic [data_width_p-1:0]     resp_data_i,
    input  load_info_s                  resp_info_i,
    input  logic [reg_addr_width_p-1:0] resp_reg_id_i,
    output logic                        int_wb_v_o,
    output logic [reg_addr_width_p-1:0] int_wb_rd_o,
    output logic [data_width_p-1:0]     int_wb_data_o,
    input  logic                        int_wb_yumi_i,
    output logic                        fp_wb_v_o,
    output logic [reg_addr_width_p-1:0] fp_wb_rd_o,
    output logic [data_width_p-1:0]     fp_wb_data_o,
    input  logic                        fp_wb_yumi_i,
    output logic                        ifetch_v_o,
    output logic [data_width_p-1:0]     ifetch_data_o,
    input  logic                        ifetch_yumi_i,
    output logic                        idle_o
);

    localparam int CNT_W = $clog2(max_out_p + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(max_out_p);

    lsu_resp_s                enq_resp, head;
    logic                     head_v, deq;
    logic [data_width_p-1:0]  aligned;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    assign enq_resp = '{load_info: resp_info_i, reg_id: resp_reg_id_i, data: resp_data_i};

    lsu_remote_resp_fifo #(.width_p($bits(lsu_resp_s))) fifo (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .enq_v_i    (resp_v_i),
        .enq_data_i (enq_resp),
        .ready_o    (resp_ready_o),
        .deq_i      (deq),
        .v_o        (head_v),
        .data_o     (head)
    );

    lsu_load_align align (
        .data_i (head.data),
        .info_i (head.load_info),
        .data_o (aligned)
    );

    always_comb begin
        int_wb_v_o    = 1'b0;
        int_wb_rd_o   = '0;
        int_wb_data_o = '0;
        fp_wb_v_o     = 1'b0;
        fp_wb_rd_o    = '0;
        fp_wb_data_o  = '0;
        ifetch_v_o    = 1'b0;
        ifetch_data_o = '0;
        if (head_v) begin
            if (head.load_info.icache_fetch) begin
                ifetch_v_o    = 1'b1;
                ifetch_data_o = head.data;
            end else if (head.load_info.float_wb) begin
                fp_wb_v_o    = 1'b1;
                fp_wb_rd_o   = head.reg_id;
                fp_wb_data_o = head.data;
            end else begin
                int_wb_v_o    = 1'b1;
                int_wb_rd_o   = head.reg_id;
                int_wb_data_o = aligned;
            end
        end
    end

    assign deq = (int_wb_v_o & int_wb_yumi_i) | (fp_wb_v_o & fp_wb_yumi_i)
               | (ifetch_v_o & ifetch_yumi_i);

    // Over/underflow is a caller bug: flag it and leave the count untouched.
    always_comb begin
        cnt_d = cnt_q;
        if (issue_v_i && !deq && cnt_q != MAX_CNT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (deq && !issue_v_i && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            assert (!(issue_v_i && !deq && cnt_q == MAX_CNT)) else $error("credit overflow");
            assert (!(deq && !issue_v_i && cnt_q == '0)) else $error("credit underflow");
            assert (!(resp_v_i && resp_ready_o && cnt_q == '0)) else $error("unsolicited response");
            assert (!(int_wb_yumi_i && !int_wb_v_o)) else $error("int yumi without valid");
            assert (!(fp_wb_yumi_i && !fp_wb_v_o)) else $error("fp yumi without valid");
            assert (!(ifetch_yumi_i && !ifetch_v_o)) else $error("ifetch yumi without valid");
        end
    end

    assign credit_avail_o = (cnt_q < MAX_CNT);
    assign idle_o         = (cnt_q == '0) && !head_v;

endmodule
